// File: rtl/processor_pkg.sv
// ============================================================================
// Module      : processor_pkg
// Description : Shared definitions for the multicycle processor: opcode and
//               ALU-op encodings, FSM state type, overflow status codes,
//               special register indices and an immediate sign-extender.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package processor_pkg;

    // Primary opcodes, instruction bits [31:27]
    localparam logic [4:0] c_OP_RTYPE = 5'b00000;
    localparam logic [4:0] c_OP_J     = 5'b00001;
    localparam logic [4:0] c_OP_BNE   = 5'b00010;
    localparam logic [4:0] c_OP_JAL   = 5'b00011;
    localparam logic [4:0] c_OP_JR    = 5'b00100;
    localparam logic [4:0] c_OP_ADDI  = 5'b00101;
    localparam logic [4:0] c_OP_BLT   = 5'b00110;
    localparam logic [4:0] c_OP_SW    = 5'b00111;
    localparam logic [4:0] c_OP_LW    = 5'b01000;
    localparam logic [4:0] c_OP_SETX  = 5'b10101;
    localparam logic [4:0] c_OP_BEX   = 5'b10110;

    // R-type ALU operations, instruction bits [6:2]
    localparam logic [4:0] c_ALU_ADD  = 5'b00000;
    localparam logic [4:0] c_ALU_SUB  = 5'b00001;
    localparam logic [4:0] c_ALU_AND  = 5'b00010;
    localparam logic [4:0] c_ALU_OR   = 5'b00011;
    localparam logic [4:0] c_ALU_SLL  = 5'b00100;
    localparam logic [4:0] c_ALU_SRA  = 5'b00101;

    // Values written to the status register when an arithmetic op overflows
    localparam logic [31:0] c_OVF_ADD  = 32'd1;
    localparam logic [31:0] c_OVF_ADDI = 32'd2;
    localparam logic [31:0] c_OVF_SUB  = 32'd3;

    // Special register indices
    localparam logic [4:0] c_RSTATUS = 5'd30;
    localparam logic [4:0] c_RRA     = 5'd31;

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4
    } state_t;

    function automatic logic [31:0] signExtend17(input logic [16:0] imm);
        return {{15{imm[16]}}, imm};
    endfunction

endpackage

`default_nettype wire

// File: rtl/processor_alu.sv
// ============================================================================
// Module      : processor_alu
// Description : 32-bit combinational ALU. add/sub report signed overflow;
//               and/or/sll/sra never overflow; unknown ops yield zero.
//   i_operandA, i_operandB : 32-bit operands
//   i_op                   : 5-bit operation select
//   i_shamt                : 5-bit shift amount (applied to operand A)
//   o_result               : 32-bit result
//   o_overflow             : signed overflow of add/sub
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module processor_alu
    import processor_pkg::*;
(
    input  logic [31:0] i_operandA,
    input  logic [31:0] i_operandB,
    input  logic [4:0]  i_op,
    input  logic [4:0]  i_shamt,
    output logic [31:0] o_result,
    output logic        o_overflow
);

    logic [31:0] w_sum;
    logic [31:0] w_diff;

    assign w_sum  = i_operandA + i_operandB;
    assign w_diff = i_operandA - i_operandB;

    always_comb begin
        o_result   = '0;
        o_overflow = 1'b0;
        case (i_op)
            c_ALU_ADD: begin
                o_result   = w_sum;
                // Same-sign operands producing an opposite-sign sum
                o_overflow = (i_operandA[31] == i_operandB[31]) &&
                             (w_sum[31] != i_operandA[31]);
            end
            c_ALU_SUB: begin
                o_result   = w_diff;
                o_overflow = (i_operandA[31] != i_operandB[31]) &&
                             (w_diff[31] != i_operandA[31]);
            end
            c_ALU_AND: o_result = i_operandA & i_operandB;
            c_ALU_OR:  o_result = i_operandA | i_operandB;
            c_ALU_SLL: o_result = i_operandA << i_shamt;
            c_ALU_SRA: o_result = $signed(i_operandA) >>> i_shamt;
            default:   o_result = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/processor.sv
// ============================================================================
// Module      : processor
// Description : Five-state multicycle processor (FETCH, DECODE, EXECUTE,
//               MEMORY, WRITEBACK). Instruction ROM, data RAM and register
//               file are external.
//   clock, reset                 : clock, async active-high reset
//   address_imem / q_imem        : ROM word address (PC) / registered data
//   ctrl_writeEnable, ctrl_writeReg, data_writeReg : regfile write port
//   ctrl_readRegA/B, data_readRegA/B               : regfile read ports
//   wren, address_dmem, data / q_dmem : RAM write port / registered data
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module processor
    import processor_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] address_imem,
    input  logic [31:0] q_imem,
    output logic        ctrl_writeEnable,
    output logic [4:0]  ctrl_writeReg,
    output logic [4:0]  ctrl_readRegA,
    output logic [4:0]  ctrl_readRegB,
    output logic [31:0] data_writeReg,
    input  logic [31:0] data_readRegA,
    input  logic [31:0] data_readRegB,
    output logic        wren,
    output logic [31:0] address_dmem,
    output logic [31:0] data,
    input  logic [31:0] q_dmem
);

    state_t      r_state;
    state_t      w_nextState;

    logic [31:0] r_pc;
    logic [31:0] r_ir;

    // Decisions captured at the end of EXECUTE
    logic [31:0] r_nextPc;
    logic        r_wbEn;
    logic [4:0]  r_wbReg;
    logic [31:0] r_wbData;
    logic        r_isLw;
    logic        r_isSw;
    logic [31:0] r_addrDmem;
    logic [31:0] r_dataDmem;

    // Regfile write index/data hold their last values outside WRITEBACK
    logic [4:0]  r_wbRegHold;
    logic [31:0] r_wbDataHold;

    // Instruction fields
    logic [4:0]  w_opcode;
    logic [4:0]  w_rd;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_shamt;
    logic [4:0]  w_aluop;
    logic [31:0] w_imm;
    logic [31:0] w_target;
    logic [31:0] w_pcPlus1;

    logic [31:0] w_aluB;
    logic [4:0]  w_aluOp;
    logic [31:0] w_aluResult;
    logic        w_aluOverflow;

    logic [31:0] w_nextPc;
    logic        w_wbEn;
    logic [4:0]  w_wbReg;
    logic [31:0] w_wbData;
    logic        w_isLw;
    logic        w_isSw;
    logic [31:0] w_wbFinal;

    assign w_opcode  = r_ir[31:27];
    assign w_rd      = r_ir[26:22];
    assign w_rs      = r_ir[21:17];
    assign w_rt      = r_ir[16:12];
    assign w_shamt   = r_ir[11:7];
    assign w_aluop   = r_ir[6:2];
    assign w_imm     = signExtend17(r_ir[16:0]);
    assign w_target  = {5'b0, r_ir[26:0]};
    assign w_pcPlus1 = r_pc + 32'd1;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = S_FETCH;
        case (r_state)
            S_FETCH:     w_nextState = S_DECODE;
            S_DECODE:    w_nextState = S_EXECUTE;
            S_EXECUTE:   w_nextState = S_MEMORY;
            S_MEMORY:    w_nextState = S_WRITEBACK;
            S_WRITEBACK: w_nextState = S_FETCH;
            default:     w_nextState = S_FETCH;
        endcase
    end

    // ------------------------------------------------------------------
    // Register read indices, driven from IR
    // ------------------------------------------------------------------
    always_comb begin
        ctrl_readRegA = w_rs;
        if (w_opcode == c_OP_JR) begin
            ctrl_readRegA = w_rd;
        end else if (w_opcode == c_OP_BEX) begin
            ctrl_readRegA = c_RSTATUS;
        end

        ctrl_readRegB = w_rt;
        if (w_opcode == c_OP_SW || w_opcode == c_OP_BNE || w_opcode == c_OP_BLT) begin
            ctrl_readRegB = w_rd;
        end
    end

    // ------------------------------------------------------------------
    // ALU: R-type uses aluop/rt; addi, lw and sw add the immediate
    // ------------------------------------------------------------------
    assign w_aluB  = (w_opcode == c_OP_RTYPE) ? data_readRegB : w_imm;
    assign w_aluOp = (w_opcode == c_OP_RTYPE) ? w_aluop : c_ALU_ADD;

    processor_alu u_alu (
        .i_operandA (data_readRegA),
        .i_operandB (w_aluB),
        .i_op       (w_aluOp),
        .i_shamt    (w_shamt),
        .o_result   (w_aluResult),
        .o_overflow (w_aluOverflow)
    );

    // ------------------------------------------------------------------
    // EXECUTE decisions: next PC and pending register write
    // ------------------------------------------------------------------
    always_comb begin
        w_nextPc = w_pcPlus1;
        w_wbEn   = 1'b0;
        w_wbReg  = w_rd;
        w_wbData = w_aluResult;
        w_isLw   = 1'b0;
        w_isSw   = 1'b0;
        case (w_opcode)
            c_OP_RTYPE: begin
                // aluops beyond sra are no-ops and write nothing
                if (w_aluop <= c_ALU_SRA) begin
                    w_wbEn = 1'b1;
                    if (w_aluOverflow) begin
                        w_wbReg  = c_RSTATUS;
                        w_wbData = (w_aluop == c_ALU_SUB) ? c_OVF_SUB : c_OVF_ADD;
                    end
                end
            end
            c_OP_ADDI: begin
                w_wbEn = 1'b1;
                if (w_aluOverflow) begin
                    w_wbReg  = c_RSTATUS;
                    w_wbData = c_OVF_ADDI;
                end
            end
            c_OP_SW: w_isSw = 1'b1;
            c_OP_LW: begin
                w_isLw = 1'b1;
                w_wbEn = 1'b1;
            end
            c_OP_J: w_nextPc = w_target;
            c_OP_BNE: begin
                if (data_readRegB != data_readRegA) begin
                    w_nextPc = w_pcPlus1 + w_imm;
                end
            end
            c_OP_JAL: begin
                w_wbEn   = 1'b1;
                w_wbReg  = c_RRA;
                w_wbData = w_pcPlus1;
                w_nextPc = w_target;
            end
            c_OP_JR: w_nextPc = data_readRegA;
            c_OP_BLT: begin
                if ($signed(data_readRegB) < $signed(data_readRegA)) begin
                    w_nextPc = w_pcPlus1 + w_imm;
                end
            end
            c_OP_SETX: begin
                w_wbEn   = 1'b1;
                w_wbReg  = c_RSTATUS;
                w_wbData = w_target;
            end
            c_OP_BEX: begin
                if (data_readRegA != 32'd0) begin
                    w_nextPc = w_target;
                end
            end
            default: ;
        endcase
        // r0 is hard-wired zero: never strobe a write to it
        if (w_wbReg == 5'd0) begin
            w_wbEn = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ir <= '0;
        end else if (r_state == S_DECODE) begin
            r_ir <= q_imem;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_nextPc   <= '0;
            r_wbEn     <= 1'b0;
            r_wbReg    <= '0;
            r_wbData   <= '0;
            r_isLw     <= 1'b0;
            r_isSw     <= 1'b0;
            r_addrDmem <= '0;
            r_dataDmem <= '0;
        end else if (r_state == S_EXECUTE) begin
            r_nextPc <= w_nextPc;
            r_wbEn   <= w_wbEn;
            r_wbReg  <= w_wbReg;
            r_wbData <= w_wbData;
            r_isLw   <= w_isLw;
            r_isSw   <= w_isSw;
            if (w_isLw || w_isSw) begin
                r_addrDmem <= w_aluResult;
            end
            if (w_isSw) begin
                r_dataDmem <= data_readRegB;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pc         <= '0;
            r_wbRegHold  <= '0;
            r_wbDataHold <= '0;
        end else if (r_state == S_WRITEBACK) begin
            r_pc         <= r_nextPc;
            r_wbRegHold  <= r_wbReg;
            r_wbDataHold <= w_wbFinal;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Loaded data is only valid during WRITEBACK, one edge after MEMORY
    assign w_wbFinal        = r_isLw ? q_dmem : r_wbData;

    assign address_imem     = r_pc;
    assign ctrl_writeEnable = (r_state == S_WRITEBACK) && r_wbEn;
    assign ctrl_writeReg    = (r_state == S_WRITEBACK) ? r_wbReg : r_wbRegHold;
    assign data_writeReg    = (r_state == S_WRITEBACK) ? w_wbFinal : r_wbDataHold;
    assign wren             = (r_state == S_MEMORY) && r_isSw;
    assign address_dmem     = r_addrDmem;
    assign data             = r_dataDmem;

endmodule

`default_nettype wire

// File: tb/tb_processor.sv
// ============================================================================
// Module      : tb_processor
// Description : Self-checking bench for processor with behavioural ROM, RAM
//               and register file. Single-instruction vectors from a table,
//               then multi-instruction sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_processor;
    import processor_pkg::*;

    logic        clock;
    logic        reset;
    logic [31:0] address_imem;
    logic [31:0] q_imem;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [4:0]  ctrl_readRegA;
    logic [4:0]  ctrl_readRegB;
    logic [31:0] data_writeReg;
    logic [31:0] data_readRegA;
    logic [31:0] data_readRegB;
    logic        wren;
    logic [31:0] address_dmem;
    logic [31:0] data;
    logic [31:0] q_dmem;

    processor dut (
        .clock            (clock),
        .reset            (reset),
        .address_imem     (address_imem),
        .q_imem           (q_imem),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .ctrl_readRegA    (ctrl_readRegA),
        .ctrl_readRegB    (ctrl_readRegB),
        .data_writeReg    (data_writeReg),
        .data_readRegA    (data_readRegA),
        .data_readRegB    (data_readRegB),
        .wren             (wren),
        .address_dmem     (address_dmem),
        .data             (data),
        .q_dmem           (q_dmem)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memories
    logic [31:0] rom  [0:63];
    logic [31:0] ram  [0:63];
    logic [31:0] regs [0:31];

    always @(posedge clock) q_imem <= rom[address_imem[5:0]];
    always @(posedge clock) q_dmem <= ram[address_dmem[5:0]];
    assign data_readRegA = regs[ctrl_readRegA];
    assign data_readRegB = regs[ctrl_readRegB];

    // Write monitor, sampled mid-cycle
    int          cyc;
    int          nWrites;
    int          nStores;
    logic [4:0]  wrReg  [0:7];
    logic [31:0] wrData [0:7];
    int          wrCyc  [0:7];
    logic [31:0] stAddr;
    logic [31:0] stData;

    always @(negedge clock) begin
        if (!reset) begin
            cyc = cyc + 1;
            if (ctrl_writeEnable) begin
                if (ctrl_writeReg != 5'd0) regs[ctrl_writeReg] = data_writeReg;
                if (nWrites < 8) begin
                    wrReg[nWrites]  = ctrl_writeReg;
                    wrData[nWrites] = data_writeReg;
                    wrCyc[nWrites]  = cyc;
                end
                nWrites = nWrites + 1;
            end
            if (wren) begin
                ram[address_dmem[5:0]] = data;
                stAddr  = address_dmem;
                stData  = data;
                nStores = nStores + 1;
            end
        end
    end

    int nChecks;
    int nErrors;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks = nChecks + 1;
        if (act !== exp) begin
            nErrors = nErrors + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Encoders
    function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] sh,
                                          input logic [4:0] op);
        return {c_OP_RTYPE, rd, rs, rt, sh, op, 2'b00};
    endfunction

    function automatic logic [31:0] itype(input logic [4:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs, input logic [16:0] imm);
        return {op, rd, rs, imm};
    endfunction

    function automatic logic [31:0] jtype(input logic [4:0] op, input logic [26:0] t);
        return {op, t};
    endfunction

    task automatic startRun();
        reset = 1'b1;
        @(posedge clock);
        #1;
        for (int i = 0; i < 32; i++) regs[i] = '0;
        for (int i = 0; i < 64; i++) begin
            rom[i] = '0;
            ram[i] = '0;
        end
        cyc     = 0;
        nWrites = 0;
        nStores = 0;
    endtask

    task automatic releaseReset();
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic runCycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] r1;
        logic [31:0] r2;
        logic        we;
        logic [4:0]  wReg;
        logic [31:0] wData;
        logic [31:0] pc;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] r1,
                                input logic [31:0] r2, input logic we, input logic [4:0] wReg,
                                input logic [31:0] wData, input logic [31:0] pc);
        vec_t v;
        v.instr = instr; v.r1 = r1; v.r2 = r2; v.we = we;
        v.wReg = wReg; v.wData = wData; v.pc = pc;
        return v;
    endfunction

    localparam int NVEC = 20;
    vec_t vecs [0:NVEC-1];

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nChecks = 0;
        nErrors = 0;
        cyc = 0; nWrites = 0; nStores = 0;
        stAddr = '0; stData = '0;

        //               instr                                    r1            r2            we  reg     data          pc
        vecs[0]  = mk(rtype(3, 1, 2, 0, c_ALU_ADD),   32'd5,        32'd7,        1, 5'd3,  32'd12,       32'd1);
        vecs[1]  = mk(rtype(3, 1, 2, 0, c_ALU_SUB),   32'd5,        32'd7,        1, 5'd3,  32'hFFFFFFFE, 32'd1);
        vecs[2]  = mk(rtype(3, 1, 2, 0, c_ALU_AND),   32'h0000F0F0, 32'h0000FF00, 1, 5'd3,  32'h0000F000, 32'd1);
        vecs[3]  = mk(rtype(3, 1, 2, 0, c_ALU_OR),    32'h0000F0F0, 32'h0000FF00, 1, 5'd3,  32'h0000FFF0, 32'd1);
        vecs[4]  = mk(rtype(3, 1, 0, 4, c_ALU_SLL),   32'h0000000F, 32'd0,        1, 5'd3,  32'h000000F0, 32'd1);
        vecs[5]  = mk(rtype(3, 1, 0, 4, c_ALU_SRA),   32'h80000000, 32'd0,        1, 5'd3,  32'hF8000000, 32'd1);
        vecs[6]  = mk(rtype(3, 1, 2, 0, c_ALU_SUB),   32'h80000000, 32'd1,        1, 5'd30, 32'd3,        32'd1);
        vecs[7]  = mk(rtype(3, 1, 2, 0, c_ALU_ADD),   32'h7FFFFFFF, 32'd1,        1, 5'd30, 32'd1,        32'd1);
        vecs[8]  = mk(itype(c_OP_ADDI, 3, 1, 17'h1FFFF), 32'h80000000, 32'd0,     1, 5'd30, 32'd2,        32'd1);
        vecs[9]  = mk(itype(c_OP_ADDI, 3, 1, 17'h1FFFD), 32'd10,    32'd0,        1, 5'd3,  32'd7,        32'd1);
        vecs[10] = mk(itype(c_OP_ADDI, 0, 1, 17'd5),  32'd1,        32'd0,        0, 5'd0,  32'd0,        32'd1);
        vecs[11] = mk(rtype(3, 1, 2, 0, 5'b00110),    32'd5,        32'd7,        0, 5'd0,  32'd0,        32'd1);
        vecs[12] = mk(jtype(5'b11111, 27'd9),         32'd5,        32'd7,        0, 5'd0,  32'd0,        32'd1);
        vecs[13] = mk(jtype(c_OP_J, 27'd100),         32'd0,        32'd0,        0, 5'd0,  32'd0,        32'd100);
        vecs[14] = mk(itype(c_OP_BNE, 1, 2, 17'd5),   32'd1,        32'd2,        0, 5'd0,  32'd0,        32'd6);
        vecs[15] = mk(itype(c_OP_BNE, 1, 2, 17'd5),   32'd3,        32'd3,        0, 5'd0,  32'd0,        32'd1);
        vecs[16] = mk(itype(c_OP_BLT, 1, 2, 17'd3),   32'hFFFFFFFB, 32'd2,        0, 5'd0,  32'd0,        32'd4);
        vecs[17] = mk(itype(c_OP_BLT, 1, 2, 17'd3),   32'd2,        32'hFFFFFFFB, 0, 5'd0,  32'd0,        32'd1);
        vecs[18] = mk(itype(c_OP_JR, 1, 0, 17'd0),    32'h33,       32'd0,        0, 5'd0,  32'd0,        32'h33);
        vecs[19] = mk(jtype(c_OP_SETX, 27'h123),      32'd0,        32'd0,        1, 5'd30, 32'h123,      32'd1);

        // Reset state
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("reset address_imem", address_imem, 32'd0);
        check("reset writeEnable", {31'd0, ctrl_writeEnable}, 32'd0);
        check("reset wren", {31'd0, wren}, 32'd0);
        check("reset writeReg", {27'd0, ctrl_writeReg}, 32'd0);

        // Single-instruction table
        for (int v = 0; v < NVEC; v++) begin
            startRun();
            rom[0]  = vecs[v].instr;
            regs[1] = vecs[v].r1;
            regs[2] = vecs[v].r2;
            releaseReset();
            runCycles(5);
            check($sformatf("vec%0d nwrites", v), nWrites, vecs[v].we ? 32'd1 : 32'd0);
            if (vecs[v].we) begin
                check($sformatf("vec%0d wreg", v), {27'd0, wrReg[0]}, {27'd0, vecs[v].wReg});
                check($sformatf("vec%0d wdata", v), wrData[0], vecs[v].wData);
                check($sformatf("vec%0d wcycle", v), wrCyc[0], 32'd5);
            end
            check($sformatf("vec%0d nextpc", v), address_imem, vecs[v].pc);
            check($sformatf("vec%0d nstores", v), nStores, 32'd0);
        end

        // jal from PC=0 (in table style, separately to check r31)
        startRun();
        rom[0] = jtype(c_OP_JAL, 27'd10);
        releaseReset();
        runCycles(5);
        check("jal0 r31", regs[31], 32'd1);
        check("jal0 pc", address_imem, 32'd10);

        // addi r1,r0,5 ; addi r2,r1,-3
        startRun();
        rom[0] = itype(c_OP_ADDI, 1, 0, 17'd5);
        rom[1] = itype(c_OP_ADDI, 2, 1, 17'h1FFFD);
        releaseReset();
        runCycles(10);
        check("seqA nwrites", nWrites, 32'd2);
        check("seqA w0 reg", {27'd0, wrReg[0]}, 32'd1);
        check("seqA w0 data", wrData[0], 32'd5);
        check("seqA w0 cycle", wrCyc[0], 32'd5);
        check("seqA w1 reg", {27'd0, wrReg[1]}, 32'd2);
        check("seqA w1 data", wrData[1], 32'd2);
        check("seqA w1 cycle", wrCyc[1], 32'd10);

        // Overflow through a shifted operand
        startRun();
        rom[0] = itype(c_OP_ADDI, 1, 0, 17'h07FFF);
        rom[1] = rtype(1, 1, 0, 16, c_ALU_SLL);
        rom[2] = rtype(2, 1, 1, 0, c_ALU_ADD);
        releaseReset();
        runCycles(15);
        check("ovf r1", regs[1], 32'h7FFF0000);
        check("ovf r2 untouched", regs[2], 32'd0);
        check("ovf r30", regs[30], 32'd1);

        // sw r1,4(r0) ; lw r3,4(r0)
        startRun();
        regs[1] = 32'd5;
        rom[0] = itype(c_OP_SW, 1, 0, 17'd4);
        rom[1] = itype(c_OP_LW, 3, 0, 17'd4);
        releaseReset();
        runCycles(10);
        check("mem nstores", nStores, 32'd1);
        check("mem store addr", stAddr, 32'd4);
        check("mem store data", stData, 32'd5);
        check("mem r3", regs[3], 32'd5);
        check("mem nwrites", nWrites, 32'd1);

        // bne taken skips one instruction, not-taken falls through
        for (int t = 0; t < 2; t++) begin
            startRun();
            regs[1] = 32'd1;
            regs[2] = (t == 0) ? 32'd2 : 32'd1;
            rom[0] = itype(c_OP_BNE, 1, 2, 17'd1);
            rom[1] = itype(c_OP_ADDI, 4, 0, 17'd1);
            rom[2] = itype(c_OP_ADDI, 5, 0, 17'd1);
            releaseReset();
            runCycles(10);
            check($sformatf("bne%0d r4", t), regs[4], (t == 0) ? 32'd0 : 32'd1);
            check($sformatf("bne%0d pc", t), address_imem, (t == 0) ? 32'd3 : 32'd2);
        end

        // jal 10 from PC=3, then jr r31
        startRun();
        rom[3]  = jtype(c_OP_JAL, 27'd10);
        rom[10] = itype(c_OP_JR, 31, 0, 17'd0);
        releaseReset();
        runCycles(20);
        check("jal r31", regs[31], 32'd4);
        check("jal pc", address_imem, 32'd10);
        runCycles(5);
        check("jr pc", address_imem, 32'd4);

        // setx 7 ; bex 20
        startRun();
        rom[0] = jtype(c_OP_SETX, 27'd7);
        rom[1] = jtype(c_OP_BEX, 27'd20);
        releaseReset();
        runCycles(10);
        check("setx r30", regs[30], 32'd7);
        check("bex pc", address_imem, 32'd20);

        // bex not taken with r30 = 0
        startRun();
        rom[0] = jtype(c_OP_BEX, 27'd20);
        releaseReset();
        runCycles(5);
        check("bex nt pc", address_imem, 32'd1);

        // Reset during EXECUTE of the second instruction
        startRun();
        rom[0] = itype(c_OP_ADDI, 1, 0, 17'd5);
        rom[1] = itype(c_OP_ADDI, 2, 0, 17'd9);
        releaseReset();
        runCycles(7);
        #2;
        reset = 1'b1;
        #1;
        check("midrst pc cleared", address_imem, 32'd0);
        check("midrst writeEnable", {31'd0, ctrl_writeEnable}, 32'd0);
        check("midrst wren", {31'd0, wren}, 32'd0);
        repeat (2) @(posedge clock);
        #1;
        check("midrst nwrites", nWrites, 32'd1);
        check("midrst r2", regs[2], 32'd0);
        cyc = 0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        runCycles(5);
        check("midrst refetch nwrites", nWrites, 32'd2);
        check("midrst refetch reg", {27'd0, wrReg[1]}, 32'd1);
        check("midrst refetch cycle", wrCyc[1], 32'd5);
        check("midrst r2 after", regs[2], 32'd0);

        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end

endmodule

`default_nettype wire
